// File: rtl/integer_file_pkg.sv
// Shared constants, types and helpers for the integer register file family.
package integer_file_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int AW_DEF     = $clog2(NREGS_DEF);

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

  // True for the hardwired-zero register. Callers widen their address to 32 bits.
  function automatic logic is_x0(input int unsigned addr);
    return (addr == 0);
  endfunction

endpackage

// File: rtl/integer_file_mp_if.sv
// Issue/writeback bus of the multi-read-port integer file.
// Handshake: there is no valid/ready pair; reads are combinational every cycle,
// and wr_en_in / rsv_en_in are single-cycle qualifiers sampled on the rising clock.
interface integer_file_mp_if
  import integer_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rs_addr_in;
  logic [NUM_RD*XLEN-1:0] rs_out;
  logic [NUM_RD-1:0]      rs_busy_out;
  logic [AW-1:0]          rd_addr_in;
  logic                   wr_en_in;
  logic [XLEN-1:0]        rd_in;
  logic                   rsv_en_in;
  logic [AW-1:0]          rsv_addr_in;
  logic                   any_busy_out;

  // Issue/writeback side
  modport master (
    output rs_addr_in, rd_addr_in, wr_en_in, rd_in, rsv_en_in, rsv_addr_in,
    input  rs_out, rs_busy_out, any_busy_out
  );

  // Register file side
  modport slave (
    input  rs_addr_in, rd_addr_in, wr_en_in, rd_in, rsv_en_in, rsv_addr_in,
    output rs_out, rs_busy_out, any_busy_out
  );
endinterface

// File: rtl/integer_file_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set by a reservation,
// cleared by the writeback to that register. x0 is never busy.
module integer_file_scoreboard
  import integer_file_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [NUM_RD*AW-1:0] rs_addr,
  output logic [NUM_RD-1:0]    rs_busy,
  output logic                 any_busy
);

  logic [NREGS-1:0] busy;

  // Clear on writeback, then set on reservation so a same-register reserve wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr_en && !is_x0(32'(wr_addr)))
        busy[wr_addr] <= 1'b0;
      if (rsv_en && !is_x0(32'(rsv_addr)))
        busy[rsv_addr] <= 1'b1;
    end
  end

  // Per-port busy lookup; busy[0] is never set so x0 reads back not-busy.
  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NUM_RD; k++)
      rs_busy[k] = busy[rs_addr[k*AW +: AW]];
  end

  // Drain/flush indicator
  assign any_busy = |busy;

endmodule

// File: rtl/integer_file_mp.sv
// Multi-read-port integer register file with write-pending scoreboard.
// Optional same-cycle write-to-read bypass: define INTEGER_FILE_BYPASS_EN.
module integer_file_mp
  import integer_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  integer_file_mp_if.slave  bus
);

  logic [XLEN-1:0]   regs [NREGS];
  logic [AW-1:0]     rs_addr_a [NUM_RD];
  logic [NUM_RD-1:0] sb_busy;
  logic [NUM_RD*XLEN-1:0] rs_out_c;
  logic [NUM_RD-1:0]      rs_busy_c;

  // Data array; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (bus.wr_en_in && !is_x0(32'(bus.rd_addr_in))) begin
      regs[bus.rd_addr_in] <= bus.rd_in;
    end
  end

  integer_file_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk_in),
    .rst_n    (reset_n_in),
    .rsv_en   (bus.rsv_en_in),
    .rsv_addr (bus.rsv_addr_in),
    .wr_en    (bus.wr_en_in),
    .wr_addr  (bus.rd_addr_in),
    .rs_addr  (bus.rs_addr_in),
    .rs_busy  (sb_busy),
    .any_busy (bus.any_busy_out)
  );

  // Split the packed read-address bus into per-port addresses.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++)
      rs_addr_a[k] = bus.rs_addr_in[k*AW +: AW];
  end

  // Read muxes, with the optional bypass of this cycle's writeback data.
  always_comb begin
    rs_out_c  = '0;
    rs_busy_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!is_x0(32'(rs_addr_a[k]))) begin
        rs_out_c[k*XLEN +: XLEN] = regs[rs_addr_a[k]];
        rs_busy_c[k]             = sb_busy[k];
      end
`ifdef INTEGER_FILE_BYPASS_EN
      // A same-register reservation means a newer producer is pending, so no bypass.
      if (reset_n_in && bus.wr_en_in && !is_x0(32'(bus.rd_addr_in)) &&
          (rs_addr_a[k] == bus.rd_addr_in) &&
          !(bus.rsv_en_in && (bus.rsv_addr_in == bus.rd_addr_in))) begin
        rs_out_c[k*XLEN +: XLEN] = bus.rd_in;
        rs_busy_c[k]             = 1'b0;
      end
`endif
    end
  end

  assign bus.rs_out      = rs_out_c;
  assign bus.rs_busy_out = rs_busy_c;

endmodule

// File: tb/tb_integer_file_mp.sv
// Self-checking bench for integer_file_mp: directed vector table, hand-written
// bypass / mid-operation reset sequences, then random traffic against a model.
module tb_integer_file_mp;
  import integer_file_pkg::*;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
  localparam int W      = NUM_RD*XLEN + NUM_RD + 1;

  // Clock / reset
  logic clk_in     = 1'b0;
  logic reset_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  integer_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) bus ();

  integer_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic            wr;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rsv;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic [1:0]      eb;
    logic            eany;
  } vec_t;

  vec_t vecs [13];

  // Reference model state for the random phase
  logic [XLEN-1:0] m_mem  [NREGS];
  logic            m_busy [NREGS];

  // Driver
  task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic rsv, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.wr_en_in    = wr;
    bus.rd_addr_in  = wa;
    bus.rd_in       = wd;
    bus.rsv_en_in   = rsv;
    bus.rsv_addr_in = ra;
    bus.rs_addr_in  = {a1, a0};
  endtask

  task automatic push_exp(input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1,
                          input logic [1:0] eb, input logic eany);
    exp_q.push_back({e1, e0, eb, eany});
  endtask

  // Scoreboard: pop one expectation and compare against the live outputs
  task automatic check_out(input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {bus.rs_out, bus.rs_busy_out, bus.any_busy_out};
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: no expectation queued, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        tests_failed++;
        $display("FAIL %s: got rs_out=%h busy=%b any=%b, expected rs_out=%h busy=%b any=%b",
                 name, act[W-1:3], act[2:1], act[0], exp[W-1:3], exp[2:1], exp[0]);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd10, 32'hABCDEF01, 1'b0, 5'd0, 5'd4,  5'd3,  32'h0,        32'h0,        2'b00, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd10, 5'd12, 32'hABCDEF01, 32'h0,        2'b00, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0, 5'd0,  5'd10, 32'h0,        32'hABCDEF01, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 5'd5,  5'd10, 32'h0,        32'hABCDEF01, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd5,  32'h0,        32'h0,        2'b11, 1'b1};
    vecs[6]  = '{1'b1, 5'd5,  32'h55,       1'b0, 5'd0, 5'd10, 5'd12, 32'hABCDEF01, 32'h0,        2'b00, 1'b1};
    vecs[7]  = '{1'b1, 5'd7,  32'h77,       1'b1, 5'd7, 5'd5,  5'd5,  32'h55,       32'h55,       2'b00, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h77,       32'h55,       2'b01, 1'b1};
    vecs[9]  = '{1'b1, 5'd9,  32'h1111,     1'b1, 5'd2, 5'd7,  5'd12, 32'h77,       32'h0,        2'b01, 1'b1};
    vecs[10] = '{1'b1, 5'd2,  32'h2222,     1'b0, 5'd0, 5'd9,  5'd7,  32'h1111,     32'h77,       2'b10, 1'b1};
    vecs[11] = '{1'b1, 5'd7,  32'h7777,     1'b0, 5'd0, 5'd2,  5'd9,  32'h2222,     32'h1111,     2'b00, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  32'h7777,     32'h0,        2'b00, 1'b0};

    // Reset held: outputs all zero
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3);
    push_exp(32'h0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(posedge clk_in);
    #2;
    check_out("reset_hold");
    @(negedge clk_in);
    reset_n_in = 1'b1;
    next_cycle();

    // Directed vector table: reads observed before the edge that applies the row's write/reserve
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rsv, vecs[i].ra, vecs[i].a0, vecs[i].a1);
      push_exp(vecs[i].e0, vecs[i].e1, vecs[i].eb, vecs[i].eany);
      @(negedge clk_in);
      check_out($sformatf("vec%0d", i));
      next_cycle();
    end

    // Bypass: read x9 on both ports while writing it
    drive(1'b1, 5'd9, 32'hDEAD0009, 1'b0, 5'd0, 5'd9, 5'd9);
`ifdef INTEGER_FILE_BYPASS_EN
    push_exp(32'hDEAD0009, 32'hDEAD0009, 2'b00, 1'b0);
`else
    push_exp(32'h1111, 32'h1111, 2'b00, 1'b0);
`endif
    @(negedge clk_in);
    check_out("bypass_same_cycle");
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    push_exp(32'hDEAD0009, 32'hDEAD0009, 2'b00, 1'b0);
    @(negedge clk_in);
    check_out("bypass_next_cycle");
    next_cycle();

    // Write + reserve same register: no bypass, busy ends set
    drive(1'b1, 5'd9, 32'h0000BEEF, 1'b1, 5'd9, 5'd9, 5'd4);
    push_exp(32'hDEAD0009, 32'h0, 2'b00, 1'b0);
    @(negedge clk_in);
    check_out("wr_rsv_same_before");
    next_cycle();
    drive(1'b1, 5'd9, 32'h0000CAFE, 1'b0, 5'd0, 5'd9, 5'd4);
`ifdef INTEGER_FILE_BYPASS_EN
    push_exp(32'h0000CAFE, 32'h0, 2'b00, 1'b1);
`else
    push_exp(32'h0000BEEF, 32'h0, 2'b01, 1'b1);
`endif
    @(negedge clk_in);
    check_out("wr_rsv_same_after");
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    push_exp(32'h0000CAFE, 32'h0, 2'b00, 1'b0);
    @(negedge clk_in);
    check_out("busy_cleared");
    next_cycle();

    // Mid-operation reset
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 5'd3, 5'd4);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    push_exp(32'h33, 32'h0, 2'b10, 1'b1);
    #1;
    check_out("pre_reset_state");
    #1;
    reset_n_in = 1'b0;
    drive(1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 5'd3, 5'd10);
    #1;
    push_exp(32'h0, 32'h0, 2'b00, 1'b0);
    check_out("async_reset_clear");
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd10);
    #1;
    push_exp(32'h0, 32'h0, 2'b00, 1'b0);
    check_out("write_in_reset_lost");
    next_cycle();
    push_exp(32'h0, 32'h0, 2'b00, 1'b0);
    check_out("no_recovery");

    // Random traffic against the model (state is all-zero after the reset above)
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      logic            wr, rsv, any;
      logic [AW-1:0]   wa, ra;
      logic [AW-1:0]   a [NUM_RD];
      logic [XLEN-1:0] wd;
      logic [XLEN-1:0] e [NUM_RD];
      logic [1:0]      eb;
      wr  = 1'($urandom_range(0, 1));
      rsv = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, 7));
      ra  = AW'($urandom_range(0, 7));
      wd  = $urandom;
      for (int k = 0; k < NUM_RD; k++) begin
        a[k] = (n % 4 == 0) ? AW'($urandom_range(0, NREGS-1)) : AW'($urandom_range(0, 7));
      end
      any = 1'b0;
      for (int r = 0; r < NREGS; r++) any |= m_busy[r];
      for (int k = 0; k < NUM_RD; k++) begin
        e[k]  = m_mem[a[k]];
        eb[k] = m_busy[a[k]];
`ifdef INTEGER_FILE_BYPASS_EN
        if (wr && wa != 0 && a[k] == wa && !(rsv && ra == wa)) begin
          e[k]  = wd;
          eb[k] = 1'b0;
        end
`endif
      end
      drive(wr, wa, wd, rsv, ra, a[0], a[1]);
      push_exp(e[0], e[1], eb, any);
      @(negedge clk_in);
      check_out($sformatf("rand%0d", n));
      if (wr && wa != 0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rsv && ra != 0) m_busy[ra] = 1'b1;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
